// File: rtl/mgs_proj_engine.sv
// Modified Gram-Schmidt projection engine: copies Phi[lambda] into U, then removes
// the projection onto each stored Q column. Optional NORM pass via `MGS_NORM_EN.
module mgs_proj_engine #(
  parameter int LANES  = 4,
  parameter int DW     = 24,
  parameter int FRAC   = 16,
  parameter int NW     = 16,
  parameter int N_COLS = 64,
  parameter int MAX_K  = 8,
  parameter int ACC_W  = 56
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(N_COLS)-1:0]     lambda,
  input  logic [$clog2(MAX_K):0]        k_cnt,
  output logic [$clog2(N_COLS*NW)-1:0]  phi_addr,
  input  logic [LANES*DW-1:0]           phi_data,
  output logic [$clog2(MAX_K*NW)-1:0]   q_addr,
  input  logic [LANES*DW-1:0]           q_rdata,
  output logic [$clog2(NW)-1:0]         u_raddr,
  input  logic [LANES*DW-1:0]           u_rdata,
  output logic [$clog2(NW)-1:0]         u_waddr,
  output logic [LANES*DW-1:0]           u_wdata,
  output logic                          u_we,
  output logic [$clog2(MAX_K)-1:0]      r_addr,
  output logic [DW-1:0]                 r_wdata,
  output logic                          r_we,
  output logic                          busy,
  output logic                          done
`ifdef MGS_NORM_EN
  ,
  output logic [ACC_W-1:0]              norm_sq,
  output logic                          norm_valid
`endif
);

  localparam int LW  = $clog2(N_COLS);
  localparam int KW  = $clog2(MAX_K) + 1;
  localparam int PAW = $clog2(N_COLS * NW);
  localparam int QAW = $clog2(MAX_K * NW);
  localparam int UAW = $clog2(NW);
  localparam int RAW = $clog2(MAX_K);
  localparam int CW  = $clog2(NW + 2);
  localparam int WW  = LANES * DW;
  localparam int XW  = ACC_W - 2 * DW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COPY = 3'd1;
  localparam logic [2:0] S_DOT  = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef MGS_NORM_EN
  localparam logic [2:0] S_NORM = 3'd5;
  localparam logic [2:0] S_TAIL = S_NORM;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] x);
    if (x > SAT_HI)      return {1'b0, {(DW-1){1'b1}}};
    else if (x < SAT_LO) return {1'b1, {(DW-1){1'b0}}};
    else                 return x[DW-1:0];
  endfunction

  logic [2:0]              state;
  logic [CW-1:0]           cnt;
  logic [RAW-1:0]          j;
  logic [KW-1:0]           k_r;
  logic [LW-1:0]           lam_r;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    r_reg;
  logic                    vld_p0;
  logic [UAW-1:0]          waddr_p0;
  logic                    vld_p1;
  logic [UAW-1:0]          waddr_p1;
  logic [WW-1:0]           wdata_p1;

  logic                    pass_act, issue, pass_end, is_norm;
  logic [UAW-1:0]          w;
  logic [KW-1:0]           k_cl;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [DW-1:0]    r_new;

  assign is_norm = `ifdef MGS_NORM_EN (state == S_NORM) `else 1'b0 `endif ;
  assign pass_act = (state == S_COPY) || (state == S_DOT) || (state == S_UPD) || is_norm;
  assign issue    = pass_act && (cnt < CW'(NW));
  assign pass_end = pass_act && (cnt == CW'(NW + 1));
  assign w        = cnt[UAW-1:0];
  assign k_cl     = (k_cnt > KW'(MAX_K)) ? KW'(MAX_K) : k_cnt;
  assign acc_sh   = acc >>> FRAC;
  assign r_new    = sat_dw(acc_sh);

  assign phi_addr = (state == S_COPY && issue) ? PAW'(lam_r) * PAW'(NW) + PAW'(w) : '0;
  assign q_addr   = ((state == S_DOT || state == S_UPD) && issue) ? QAW'(j) * QAW'(NW) + QAW'(w) : '0;
  assign u_raddr  = ((state == S_DOT || state == S_UPD || is_norm) && issue) ? w : '0;
  assign u_we     = vld_p1;
  assign u_waddr  = waddr_p1;
  assign u_wdata  = wdata_p1;
  assign r_we     = (state == S_DOT) && pass_end;
  assign r_addr   = j;
  assign r_wdata  = r_we ? r_new : r_reg;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
`ifdef MGS_NORM_EN
  assign norm_valid = done;
`endif

  // Pass sequencing: NW address cycles, one read-latency cycle, one register/write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      j     <= '0;
      k_r   <= '0;
      lam_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_COPY;
            cnt   <= '0;
            j     <= '0;
            k_r   <= k_cl;
            lam_r <= lambda;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (pass_end) begin
            cnt <= '0;
            case (state)
              S_COPY: state <= (k_r != '0) ? S_DOT : S_TAIL;
              S_DOT:  state <= S_UPD;
              S_UPD: begin
                if ((KW'(j) + KW'(1)) < k_r) begin
                  j     <= j + RAW'(1);
                  state <= S_DOT;
                end else begin
                  state <= S_TAIL;
                end
              end
              default: state <= S_DONE;
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Lane arithmetic on the returned read data
  logic signed [DW-1:0]    ql, ul;
  logic signed [2*DW-1:0]  qx, ux, rx, ax, pd, pu;
  logic signed [ACC_W-1:0] diff, dot_sum;
  logic [WW-1:0]           upd_word;

  always_comb begin
    dot_sum  = '0;
    upd_word = '0;
    ql = '0; ul = '0; qx = '0; ux = '0; rx = '0; ax = '0; pd = '0; pu = '0; diff = '0;
    for (int l = 0; l < LANES; l++) begin
      ql   = q_rdata[l*DW +: DW];
      ul   = u_rdata[l*DW +: DW];
      qx   = {{DW{ql[DW-1]}}, ql};
      ux   = {{DW{ul[DW-1]}}, ul};
      rx   = {{DW{r_reg[DW-1]}}, r_reg};
      ax   = is_norm ? ux : qx;
      pd   = ax * ux;
      dot_sum = dot_sum + {{XW{pd[2*DW-1]}}, pd};
      pu   = (rx * qx) >>> FRAC;
      diff = {{XW{ux[2*DW-1]}}, ux} - {{XW{pu[2*DW-1]}}, pu};
      upd_word[l*DW +: DW] = sat_dw(diff);
    end
  end

  // p0: address issued -> read data valid; p1: registered U write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      waddr_p0 <= '0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      acc      <= '0;
      r_reg    <= '0;
`ifdef MGS_NORM_EN
      norm_sq  <= '0;
`endif
    end else begin
      vld_p0   <= issue;
      waddr_p0 <= w;
      vld_p1   <= vld_p0 && (state == S_COPY || state == S_UPD);
      if (vld_p0 && (state == S_COPY || state == S_UPD)) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= (state == S_COPY) ? phi_data : upd_word;
      end
      if ((state == S_DOT || is_norm) && cnt == '0)
        acc <= '0;
      else if ((state == S_DOT || is_norm) && vld_p0)
        acc <= acc + dot_sum;
      if (r_we)
        r_reg <= r_new;
`ifdef MGS_NORM_EN
      if (is_norm && pass_end)
        norm_sq <= acc_sh;
`endif
    end
  end

endmodule

// File: doc/mgs_proj_engine.md
Name: mgs_proj_engine

Overview:
- Parametrised successor to the OMP Block-B Modified Gram-Schmidt stage.
- Copies the selected dictionary column Phi[lambda] into the residual buffer U, then runs k_cnt MGS projection steps against the stored orthonormal columns Q[0..k_cnt-1].
- Each step writes the coefficient r_j to R and updates U in place; U is left un-normalised.
- Sits between the atom-selection block (supplies lambda) and the normalisation/back-substitution blocks.

Parameters:
- LANES, 4, signed lanes packed per memory word.
- DW, 24, lane width (two's complement, FRAC fractional bits).
- FRAC, 16, fractional bits.
- NW, 16, words per column (vector length = LANES*NW).
- N_COLS, 64, dictionary columns in Phi.
- MAX_K, 8, maximum stored Q columns.
- ACC_W, 56, dot-product accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request.
- lambda  in  clog2(N_COLS)  column index, sampled on accepted start.
- k_cnt  in  clog2(MAX_K)+1  number of Q columns to project out; sampled on accepted start.
- phi_addr  out  clog2(N_COLS*NW)  Phi read address, = lambda*NW+w.
- phi_data  in  LANES*DW  Phi read data, valid 1 cycle after address.
- q_addr  out  clog2(MAX_K*NW)  Q read address, = j*NW+w.
- q_rdata  in  LANES*DW  Q read data, 1-cycle latency.
- u_raddr  out  clog2(NW)  U read address.
- u_rdata  in  LANES*DW  U read data, 1-cycle latency.
- u_waddr  out  clog2(NW)  U write address.
- u_wdata  out  LANES*DW  U write data.
- u_we  out  1  U write enable.
- r_addr  out  clog2(MAX_K)  R write address (= j).
- r_wdata  out  DW  R coefficient.
- r_we  out  1  R write strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator and r register cleared.
- Reset mid-operation aborts immediately; no further writes occur.

FSM states:
- IDLE -> COPY on start. start while busy is ignored.
- COPY -> DOT(j=0) if k>0, else DONE.
- DOT(j) -> UPD(j).
- UPD(j) -> DOT(j+1) if j+1<k, else DONE.
- DONE -> IDLE. done=1 for exactly this one cycle; busy=0 in the same cycle.

Pass timing:
- Every pass (COPY, DOT, UPD) takes exactly NW+2 cycles: NW address-issue cycles, 1 read-latency cycle, 1 register/write cycle.
- done is asserted (2k+1)*(NW+2)+1 cycles after the start cycle.
- k_cnt > MAX_K is clamped to MAX_K.

COPY pass:
- Reads phi word w and writes it to u[w] unchanged (u_we pulses NW times).

DOT pass:
- Reads q[j][w] and u[w].
- acc += sum over lanes of sext(q_l*u_l); products are full 2DW width, sign-extended to ACC_W.
- acc is cleared at the pass start.
- At pass end: r_j = sat_DW(acc >>> FRAC), using an arithmetic shift.
- r_j is written with r_we=1 for one cycle on the last cycle of the pass and is held in a register.

UPD pass:
- Reads q[j][w] and u[w].
- Per lane: u_l' = sat_DW(u_l - ((r_j*q_l) >>> FRAC)); written to u[w].
- u_waddr trails u_raddr by 2 cycles, so a write never conflicts with a same-pass read of the same word.

Saturation:
- Clamps to [-2^(DW-1), 2^(DW-1)-1].
- Applies to r and to every U lane.

Optional Feature:
- Macro: MGS_NORM_EN.
- Defined:
  - Adds a NORM pass after the last UPD (or after COPY if k=0), NW+2 cycles long.
  - Accumulates the sum of squares of the final U lanes.
  - Output norm_sq (ACC_W, = acc >>> FRAC, unsaturated) is held until the next accepted start.
  - norm_valid pulses together with done.
  - done latency grows by NW+2.
- Undefined: no NORM state and no norm_sq/norm_valid ports.

Test Plan:
- Reset with rst_n=0 mid-sim -> all outputs 0, busy=0, no we pulses; release -> IDLE.
- k_cnt=0, lambda=3, Phi col 3 = ramp words -> U equals ramp, r_we never asserted, done 19 cycles after start (NW=16).
- k_cnt=1, Q0 = e0 (word0 lane0 = 0x010000), Phi word0 lane0 = 0x028000, all other lanes 0x001000:
  - r0 = 0x028000 at r_addr 0.
  - U word0 lane0 = 0x000000; other lanes 0x001000.
  - done at cycle 55.
- k_cnt=1, Q0 and Phi all lanes 0x7FFFFF -> r0 = 0x7FFFFF (saturated); U lanes saturate to -0x800000 bound.
- start pulsed again while busy, and k_cnt=9 -> second start ignored; k clamped to 8 (R writes at addresses 0..7 only).
- MGS_NORM_EN defined, k_cnt=0, all lanes 0x010000 -> norm_sq = 64*0x010000 = 0x400000; norm_valid coincides with done at cycle 37.
